// File: rtl/icache_core.sv
// icache_core: 2-way set-associative read-only instruction cache with LRU replacement and AXI line refill.
// Optional hit/miss counters are built when ICACHE_PERF_CNT_EN is defined.
module icache_core #(
  parameter int INDEX_W = 7,
  parameter int WAYS = 2
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         cpu_req,
  input  logic [31:0]  cpu_addr,
  input  logic         cpu_cached,
  input  logic         cpu_stall,
  output logic [31:0]  cpu_rdata,
  output logic         cpu_rvalid,
  output logic         icache_stall,
  output logic         axi_req_o,
  output logic [31:0]  axi_addr_o,
  input  logic         axi_rend_i,
  input  logic [255:0] axi_data_i,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
);
  localparam int TAG_W = 27 - INDEX_W;
  localparam int SETS = 1 << INDEX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REFILL, RESP} state_t;
  state_t state, state_n;

  logic [31:0] addr_q;
  logic [31:0] resp_q;
  logic victim_q;
  logic [TAG_W-1:0] tag_mem [WAYS][SETS];
  logic [255:0] data_mem [WAYS][SETS];
  logic [WAYS-1:0][SETS-1:0] valid;
  logic [SETS-1:0] lru;

  logic [TAG_W-1:0] tag;
  logic [INDEX_W-1:0] idx;
  logic [2:0] wsel;
  logic hit0, hit1, hit, hit_way, victim, accept, load;
  logic [255:0] hit_line;
  logic [31:0] hit_word;
  logic unused;

  assign unused = ^cpu_addr[1:0];
  assign tag = addr_q[31 -: TAG_W];
  assign idx = addr_q[INDEX_W+4:5];
  assign wsel = addr_q[4:2];
  assign hit0 = valid[0][idx] && tag_mem[0][idx] == tag;
  assign hit1 = valid[1][idx] && tag_mem[1][idx] == tag;
  assign hit = hit0 | hit1;
  assign hit_way = !hit0;
  assign hit_line = data_mem[hit_way][idx];
  assign hit_word = hit_line[{wsel, 5'b0} +: 32];
  // Invalid ways are filled first (way0 preferred) before evicting the LRU way
  assign victim = !valid[0][idx] ? 1'b0 : !valid[1][idx] ? 1'b1 : lru[idx];
  assign accept = cpu_req & cpu_cached;

  assign cpu_rvalid = (state == LOOKUP && hit) || state == RESP;
  assign cpu_rdata = state == RESP ? resp_q : (state == LOOKUP && hit) ? hit_word : 32'h0;
  assign icache_stall = state == MISS || state == REFILL || (state == LOOKUP && !hit);
  assign axi_req_o = state == MISS;
  assign axi_addr_o = state == MISS ? {addr_q[31:5], 5'b0} : 32'h0;
  // A new request is taken when idle or when the current response is consumed
  assign load = accept && (state == IDLE || (cpu_rvalid && !cpu_stall));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? LOOKUP : IDLE;
      LOOKUP:  state_n = !hit ? MISS : cpu_stall ? LOOKUP : accept ? LOOKUP : IDLE;
      MISS:    state_n = REFILL;
      REFILL:  state_n = axi_rend_i ? RESP : REFILL;
      RESP:    state_n = cpu_stall ? RESP : accept ? LOOKUP : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      addr_q <= '0;
      resp_q <= '0;
      victim_q <= 1'b0;
      valid <= '0;
      lru <= '0;
    end else begin
      state <= state_n;
      if (load) addr_q <= cpu_addr;
      if (state == LOOKUP && !hit) victim_q <= victim;
      if (state == LOOKUP && hit) lru[idx] <= !hit_way;
      if (state == REFILL && axi_rend_i) begin
        valid[victim_q][idx] <= 1'b1;
        lru[idx] <= !victim_q;
        resp_q <= axi_data_i[{wsel, 5'b0} +: 32];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (state == REFILL && axi_rend_i) begin
      tag_mem[victim_q][idx] <= tag;
      data_mem[victim_q][idx] <= axi_data_i;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic held;
  // held marks a stalled response so a hit is counted once per request
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      held <= 1'b0;
      hit_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      held <= cpu_rvalid && cpu_stall;
      if (state == LOOKUP && hit && !held) hit_cnt <= hit_cnt + 32'd1;
      if (state == LOOKUP && !hit) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`else
  assign hit_cnt = '0;
  assign miss_cnt = '0;
`endif
endmodule

// File: tb/tb_icache_core.sv
// tb_icache_core: scoreboard bench for icache_core; stimulus queues expected words and refill addresses, a monitor checks them.
module tb_icache_core;
  logic aclk = 1'b0, aresetn = 1'b0;
  logic cpu_req = 1'b0, cpu_cached = 1'b0, cpu_stall = 1'b0, axi_rend_i = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [255:0] axi_data_i = '0;
  logic [31:0] cpu_rdata, axi_addr_o, hit_cnt, miss_cnt;
  logic cpu_rvalid, icache_stall, axi_req_o;

  int checks = 0, passed = 0, exp_hits = 0, exp_miss = 0;
  logic [31:0] exp_data[$];
  logic [31:0] exp_axi[$];

  icache_core dut (
    .aclk(aclk), .aresetn(aresetn), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_cached(cpu_cached), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid), .icache_stall(icache_stall), .axi_req_o(axi_req_o),
    .axi_addr_o(axi_addr_o), .axi_rend_i(axi_rend_i), .axi_data_i(axi_data_i),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 aclk = ~aclk;

  function automatic logic [255:0] line(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = base + 32'(k);
    return l;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge aclk) begin
    if (aresetn) begin
      if (cpu_rvalid) begin
        if (exp_data.size() == 0) check("unexpected rvalid", 32'(cpu_rvalid), 32'h0);
        else begin
          check("rdata", cpu_rdata, exp_data[0]);
          if (!cpu_stall) void'(exp_data.pop_front());
        end
      end
      if (axi_req_o) begin
        if (exp_axi.size() == 0) check("unexpected axi_req", 32'(axi_req_o), 32'h0);
        else check("axi_addr", axi_addr_o, exp_axi.pop_front());
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a);
    cpu_req = 1'b1;
    cpu_cached = 1'b1;
    cpu_addr = a;
    step();
    cpu_req = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!axi_req_o && n < 20) begin
      step();
      n++;
    end
    check("axi_req seen", 32'(axi_req_o), 32'h1);
  endtask

  task automatic hit(input logic [31:0] a, input logic [31:0] d);
    exp_data.push_back(d);
    exp_hits++;
    issue(a);
    step();
  endtask

  task automatic miss(input logic [31:0] a, input logic [31:0] base);
    exp_axi.push_back({a[31:5], 5'b0});
    exp_data.push_back(base + 32'(a[4:2]));
    exp_miss++;
    issue(a);
    wait_req();
    step(2);
    axi_rend_i = 1'b1;
    axi_data_i = line(base);
    step();
    axi_rend_i = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #2;
    check("reset rdata", cpu_rdata, 32'h0);
    check("reset rvalid", 32'(cpu_rvalid), 32'h0);
    check("reset stall", 32'(icache_stall), 32'h0);
    check("reset axi_req", 32'(axi_req_o), 32'h0);
    check("reset axi_addr", axi_addr_o, 32'h0);
    check("reset hit_cnt", hit_cnt, 32'h0);
    check("reset miss_cnt", miss_cnt, 32'h0);
    step(2);
    aresetn = 1'b1;
    step();
    miss(32'h1FC00004, 32'hA0);
    for (int i = 0; i < 8; i++) exp_data.push_back(32'hA0 + 32'(i));
    exp_hits += 8;
    cpu_req = 1'b1;
    cpu_cached = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cpu_addr = 32'h1FC00000 + 32'(4 * i);
      step();
    end
    cpu_req = 1'b0;
    step();
    exp_data.push_back(32'hA2);
    exp_hits++;
    issue(32'h1FC00008);
    cpu_stall = 1'b1;
    step(3);
    cpu_stall = 1'b0;
    step();
    cpu_req = 1'b1;
    cpu_cached = 1'b0;
    cpu_addr = 32'hBFC00000;
    step();
    check("uncached stall", 32'(icache_stall), 32'h0);
    check("uncached rvalid", 32'(cpu_rvalid), 32'h0);
    step();
    check("uncached stall 2", 32'(icache_stall), 32'h0);
    cpu_req = 1'b0;
    exp_axi.push_back(32'h00005020);
    issue(32'h00005024);
    wait_req();
    step();
    aresetn = 1'b0;
    #2;
    check("midreset rvalid", 32'(cpu_rvalid), 32'h0);
    check("midreset stall", 32'(icache_stall), 32'h0);
    check("midreset miss_cnt", miss_cnt, 32'h0);
    aresetn = 1'b1;
    exp_hits = 0;
    exp_miss = 0;
    step();
    axi_rend_i = 1'b1;
    axi_data_i = line(32'h500);
    step();
    axi_rend_i = 1'b0;
    check("late rend rvalid", 32'(cpu_rvalid), 32'h0);
    check("late rend stall", 32'(icache_stall), 32'h0);
    miss(32'h00005024, 32'h500);
    miss(32'h00000000, 32'h100);
    miss(32'h00001000, 32'h200);
    hit(32'h00000000, 32'h100);
    miss(32'h00002000, 32'h300);
    hit(32'h00000000, 32'h100);
    miss(32'h00001004, 32'h200);
    miss(32'hFFFFFFE0, 32'h700);
    hit(32'hFFFFFFFC, 32'h707);
    step(2);
`ifdef ICACHE_PERF_CNT_EN
    check("hit_cnt", hit_cnt, 32'(exp_hits));
    check("miss_cnt", miss_cnt, 32'(exp_miss));
`else
    check("hit_cnt", hit_cnt, 32'h0);
    check("miss_cnt", miss_cnt, 32'h0);
`endif
    check("pending responses", 32'(exp_data.size()), 32'h0);
    check("pending refills", 32'(exp_axi.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
